// File: rtl/spi_slave.sv
// spi_slave: SPI target (slave) with selectable CPOL/CPHA, oversampled by clk.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   cpol, cpha        SPI mode; captured when the frame starts
//   spi_clk, cs_n,
//   mosi              raw SPI inputs from the master (asynchronous to clk)
//   miso, miso_oe     serial data back to the master and its output enable
//   tx_data, tx_ack   next word to send; tx_ack pulses when it is loaded
//   rx_data, rx_valid last complete received word; rx_valid pulses on update
//   busy              high while a chip-select window is open
//
// FSM states:
//   state  | meaning
//   IDLE   | cs_n high; spi_clk ignored, miso tri-stated (driven 0)
//   ACTIVE | cs_n low; shifting frames, back-to-back while cs_n stays low
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   mosi_dly_q;

  state_t                 state_q;
  logic                   cpol_q;
  logic                   cpha_q;
  logic [DATA_W-1:0]      tx_shift_q;
  logic [DATA_W-1:0]      rx_shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   miso_q;
  logic                   tx_ack_q;
  logic                   done_q;
  logic                   rx_valid_q;
  logic [DATA_W-1:0]      rx_data_q;

  logic sclk_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  // Synchronizers plus the one-cycle history used for edge detection.
  // cs_n resets to deselected and spi_clk to low so no edge is seen on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      mosi_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q[0] <= spi_clk;
      cs_sync_q[0]   <= cs_n;
      mosi_sync_q[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      mosi_dly_q  <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Mode decode uses the values captured at frame start.
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      tx_ack_q   <= 1'b0;
      done_q     <= 1'b0;
      // A completed frame publishes one cycle after the wrap, so a cs_n rise
      // right after the last bit cannot cancel it.
      rx_valid_q <= done_q;
      if (done_q) begin
        rx_data_q <= rx_shift_q;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= ACTIVE;
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            tx_shift_q <= tx_data;
            tx_ack_q   <= 1'b1;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= cpha ? 1'b0 : tx_data[DATA_W-1];
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // Mid-frame deselect drops partial bits; any coincident edge is ignored.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
          end else if (bit_cnt_q == CNT_W'(DATA_W)) begin
            bit_cnt_q  <= '0;
            done_q     <= 1'b1;
            tx_shift_q <= tx_data;
            tx_ack_q   <= 1'b1;
            if (!cpha_q) begin
              miso_q <= tx_data[DATA_W-1];
            end
          end else begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_dly_q};
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end
            // A shift edge at bit_cnt 0 is the frame boundary: with cpha=0 the
            // MSB is already on miso, with cpha=1 this edge only presents it.
            if (shift_edge) begin
              if (bit_cnt_q != '0) begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                miso_q     <= tx_shift_q[DATA_W-2];
              end else if (cpha_q) begin
                miso_q <= tx_shift_q[DATA_W-1];
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = miso_q & busy;
  assign tx_ack   = tx_ack_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
